// File: rtl/gb_irq_pkg.sv
// Shared interrupt-controller definitions: dispatch FSM states, vector layout
// and IRQ source indices.
package gb_irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HALT    = 3'd1,
    ST_WAIT1   = 3'd2,
    ST_WAIT2   = 3'd3,
    ST_PUSH_HI = 3'd4,
    ST_PUSH_LO = 3'd5,
    ST_JUMP    = 3'd6
  } irq_state_e;

  localparam logic [15:0] IRQ_VEC_BASE   = 16'h0040;
  localparam logic [15:0] IRQ_VEC_STRIDE = 16'd8;

  localparam logic [2:0] IRQ_VBLANK = 3'd0;
  localparam logic [2:0] IRQ_STAT   = 3'd1;
  localparam logic [2:0] IRQ_TIMER  = 3'd2;
  localparam logic [2:0] IRQ_SERIAL = 3'd3;
  localparam logic [2:0] IRQ_JOYP   = 3'd4;

  function automatic logic [15:0] irq_vector(input logic [2:0] idx);
    return IRQ_VEC_BASE + IRQ_VEC_STRIDE * {13'd0, idx};
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder for the five IRQ lines: the lowest set bit wins.
module irq_priority_enc
  import gb_irq_pkg::*;
(
  input  logic [4:0] i_req,
  output logic       o_valid,
  output logic [2:0] o_idx
);

  // Scan from JOYP down to VBlank so the lowest set bit is the last written.
  always_comb begin
    o_idx = IRQ_VBLANK;
    for (int i = 4; i >= 0; i--) begin
      if (i_req[i]) o_idx = 3'(i);
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatch sequencer (IME/EI delay, HALT wake, 5 M-cycle vectoring).
// Optional macro IRQ_DISPATCH_CANCEL_EN re-selects the source at the end of PUSH_HI.
module irq_dispatch
  import gb_irq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        m_tick,
  input  logic [4:0]  IF_data,
  input  logic [4:0]  IE_data,
  input  logic        cpu_ei,
  input  logic        cpu_di,
  input  logic        cpu_reti,
  input  logic        cpu_halt,
  input  logic        instr_boundary,
  input  logic [15:0] pc,
  output logic        ime,
  output logic        halted,
  output logic        busy,
  output logic        push_we,
  output logic [7:0]  push_data,
  output logic        pc_load,
  output logic [15:0] pc_dout,
  output logic        IF_ack_we,
  output logic [7:0]  IF_ack_dout
);

  irq_state_e  r_state;
  logic        r_ime;
  logic        r_ei_delay;
  logic [15:0] r_pc;
  logic [2:0]  r_idx;
  logic        r_vld;
  logic        r_push_we;
  logic [7:0]  r_push_data;
  logic        r_pc_load;
  logic [15:0] r_pc_dout;
  logic        r_if_ack_we;
  logic [7:0]  r_if_ack_dout;

  logic [4:0]  w_pending;
  logic        w_pend_vld;
  logic [2:0]  w_pend_idx;
  logic        w_start;
  logic [4:0]  w_if_cleared;

  assign w_pending = IF_data & IE_data;

  irq_priority_enc u_prio (
    .i_req   (w_pending),
    .o_valid (w_pend_vld),
    .o_idx   (w_pend_idx)
  );

  assign w_start = m_tick && w_pend_vld && r_ime &&
                   (((r_state == ST_IDLE) && instr_boundary) || (r_state == ST_HALT));

  assign w_if_cleared = IF_data & ~(5'b00001 << r_idx);

  always_ff @(posedge clk) begin
    r_push_we     <= 1'b0;
    r_push_data   <= 8'h00;
    r_pc_load     <= 1'b0;
    r_pc_dout     <= 16'h0000;
    r_if_ack_we   <= 1'b0;
    r_if_ack_dout <= 8'h00;
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ime      <= 1'b0;
      r_ei_delay <= 1'b0;
    end else begin
      if (m_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (w_start)       r_state <= ST_WAIT1;
            else if (cpu_halt) r_state <= ST_HALT;
          end
          ST_HALT: begin
            if (w_pend_vld) r_state <= r_ime ? ST_WAIT1 : ST_IDLE;
          end
          ST_WAIT1: r_state <= ST_WAIT2;
          ST_WAIT2: r_state <= ST_PUSH_HI;
          ST_PUSH_HI: begin
            r_push_we   <= 1'b1;
            r_push_data <= r_pc[15:8];
            r_state     <= ST_PUSH_LO;
          end
          ST_PUSH_LO: begin
            r_push_we   <= 1'b1;
            r_push_data <= r_pc[7:0];
            if (r_vld) begin
              r_if_ack_we   <= 1'b1;
              r_if_ack_dout <= {3'b111, w_if_cleared};
            end
            r_state <= ST_JUMP;
          end
          ST_JUMP: begin
            r_pc_load <= 1'b1;
            r_pc_dout <= r_vld ? irq_vector(r_idx) : 16'h0000;
            r_state   <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
      // A dispatch start overrides any EI/DI/RETI seen on the same clock.
      if (w_start) begin
        r_ime      <= 1'b0;
        r_ei_delay <= 1'b0;
      end else if (m_tick) begin
        if (cpu_di) begin
          r_ime      <= 1'b0;
          r_ei_delay <= 1'b0;
        end else begin
          if (r_ei_delay && instr_boundary) begin
            r_ime      <= 1'b1;
            r_ei_delay <= 1'b0;
          end
          if (cpu_reti) r_ime      <= 1'b1;
          if (cpu_ei)   r_ei_delay <= 1'b1;
        end
      end
    end
  end

  // Return address and serviced source, captured for the push/ack/jump stages.
  always_ff @(posedge clk) begin
    if (w_start) r_pc <= pc;
`ifdef IRQ_DISPATCH_CANCEL_EN
    if (m_tick && (r_state == ST_PUSH_HI)) begin
      r_idx <= w_pend_idx;
      r_vld <= w_pend_vld;
    end
`else
    if (w_start) begin
      r_idx <= w_pend_idx;
      r_vld <= w_pend_vld;
    end
`endif
  end

  assign ime         = r_ime;
  assign halted      = (r_state == ST_HALT);
  assign busy        = (r_state == ST_WAIT1) || (r_state == ST_WAIT2) ||
                       (r_state == ST_PUSH_HI) || (r_state == ST_PUSH_LO) ||
                       (r_state == ST_JUMP);
  assign push_we     = r_push_we;
  assign push_data   = r_push_data;
  assign pc_load     = r_pc_load;
  assign pc_dout     = r_pc_dout;
  assign IF_ack_we   = r_if_ack_we;
  assign IF_ack_dout = r_if_ack_dout;

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch; bus pulses are matched against a queue of
// expected push / IF-ack / PC-load events.
module tb_irq_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_tick;
  logic [4:0]  IF_data;
  logic [4:0]  IE_data;
  logic        cpu_ei;
  logic        cpu_di;
  logic        cpu_reti;
  logic        cpu_halt;
  logic        instr_boundary;
  logic [15:0] pc;
  logic        ime;
  logic        halted;
  logic        busy;
  logic        push_we;
  logic [7:0]  push_data;
  logic        pc_load;
  logic [15:0] pc_dout;
  logic        IF_ack_we;
  logic [7:0]  IF_ack_dout;

  always #5 clk = ~clk;

  irq_dispatch dut (
    .clk            (clk),
    .rst            (rst),
    .m_tick         (m_tick),
    .IF_data        (IF_data),
    .IE_data        (IE_data),
    .cpu_ei         (cpu_ei),
    .cpu_di         (cpu_di),
    .cpu_reti       (cpu_reti),
    .cpu_halt       (cpu_halt),
    .instr_boundary (instr_boundary),
    .pc             (pc),
    .ime            (ime),
    .halted         (halted),
    .busy           (busy),
    .push_we        (push_we),
    .push_data      (push_data),
    .pc_load        (pc_load),
    .pc_dout        (pc_dout),
    .IF_ack_we      (IF_ack_we),
    .IF_ack_dout    (IF_ack_dout)
  );

  localparam logic [1:0] K_PUSH = 2'd0;
  localparam logic [1:0] K_ACK  = 2'd1;
  localparam logic [1:0] K_PC   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] data;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [15:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic match_ev(input string tag, input logic [1:0] kind, input logic [15:0] data);
    ev_t e;
    n_checks++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_unexpected: observed pulse data %h expected no pulse", tag, data);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_kind"}, {14'd0, kind}, {14'd0, e.kind});
      chk({tag, "_data"}, data, e.data);
    end
  endtask

  // Pulse monitor: every strobe must match the next expected event, and
  // idle data buses must read zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (push_we)   match_ev("push", K_PUSH, {8'h00, push_data});
      else           chk("push_data_idle", {8'h00, push_data}, 16'h0000);
      if (IF_ack_we) match_ev("ifack", K_ACK, {8'h00, IF_ack_dout});
      else           chk("ifack_data_idle", {8'h00, IF_ack_dout}, 16'h0000);
      if (pc_load)   match_ev("pcload", K_PC, pc_dout);
      else           chk("pc_dout_idle", pc_dout, 16'h0000);
    end
  end

  task automatic tick();
    m_tick = 1'b1;
    @(negedge clk);
    m_tick = 1'b0;
    cpu_ei = 1'b0;
    cpu_di = 1'b0;
    cpu_reti = 1'b0;
    cpu_halt = 1'b0;
    instr_boundary = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic reti_tick();
    cpu_reti = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; m_tick = 1'b0; IF_data = 5'h00; IE_data = 5'h00;
    cpu_ei = 1'b0; cpu_di = 1'b0; cpu_reti = 1'b0; cpu_halt = 1'b0;
    instr_boundary = 1'b0; pc = 16'h0000;
    repeat (3) @(negedge clk);
    chk1("rst_ime", ime, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_push_we", push_we, 1'b0);
    chk1("rst_pc_load", pc_load, 1'b0);
    chk1("rst_ifack_we", IF_ack_we, 1'b0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic Timer dispatch from PC 0x1234
    reti_tick();
    chk1("reti_ime", ime, 1'b1);
    IF_data = 5'h04; IE_data = 5'h04; pc = 16'h1234; instr_boundary = 1'b1;
    expect_ev(K_PUSH, 16'h0012);
    expect_ev(K_PUSH, 16'h0034);
    expect_ev(K_ACK,  16'h00E0);
    expect_ev(K_PC,   16'h0050);
    tick();
    chk1("timer_busy", busy, 1'b1);
    chk1("timer_ime", ime, 1'b0);
    repeat (5) tick();
    chk1("timer_done_busy", busy, 1'b0);
    chk("timer_sb_empty", 16'(sb.size()), 16'd0);

    // All sources pending: VBlank wins
    IF_data = 5'h00;
    reti_tick();
    IF_data = 5'h1F; IE_data = 5'h1F; pc = 16'hABCD; instr_boundary = 1'b1;
    expect_ev(K_PUSH, 16'h00AB);
    expect_ev(K_PUSH, 16'h00CD);
    expect_ev(K_ACK,  16'h00FE);
    expect_ev(K_PC,   16'h0040);
    tick();
    chk1("all_busy", busy, 1'b1);
    repeat (5) tick();
    chk("all_sb_empty", 16'(sb.size()), 16'd0);

    // EI delay: no dispatch at the first boundary, dispatch at the next
    IF_data = 5'h00;
    cpu_ei = 1'b1;
    tick();
    chk1("ei_ime_delayed", ime, 1'b0);
    IF_data = 5'h01; IE_data = 5'h01; pc = 16'h0100; instr_boundary = 1'b1;
    tick();
    chk1("ei_ime_set", ime, 1'b1);
    chk1("ei_no_dispatch", busy, 1'b0);
    expect_ev(K_PUSH, 16'h0001);
    expect_ev(K_PUSH, 16'h0000);
    expect_ev(K_ACK,  16'h00E0);
    expect_ev(K_PC,   16'h0040);
    instr_boundary = 1'b1;
    tick();
    chk1("ei_dispatch_busy", busy, 1'b1);
    chk1("ei_dispatch_ime", ime, 1'b0);
    repeat (5) tick();
    chk("ei_sb_empty", 16'(sb.size()), 16'd0);

    // HALT with IME=0 wakes to IDLE, no dispatch
    IF_data = 5'h00;
    cpu_halt = 1'b1;
    tick();
    chk1("halt_entered", halted, 1'b1);
    IF_data = 5'h01; IE_data = 5'h01;
    tick();
    chk1("halt_wake_halted", halted, 1'b0);
    chk1("halt_wake_busy", busy, 1'b0);
    repeat (2) tick();
    chk1("halt_idle_busy", busy, 1'b0);

    // HALT with IME=1 wakes straight into a STAT dispatch
    IF_data = 5'h00;
    reti_tick();
    cpu_halt = 1'b1;
    tick();
    chk1("halt2_entered", halted, 1'b1);
    IF_data = 5'h02; IE_data = 5'h02; pc = 16'h2000;
    expect_ev(K_PUSH, 16'h0020);
    expect_ev(K_PUSH, 16'h0000);
    expect_ev(K_ACK,  16'h00E0);
    expect_ev(K_PC,   16'h0048);
    tick();
    chk1("halt2_halted", halted, 1'b0);
    chk1("halt2_busy", busy, 1'b1);
    repeat (5) tick();
    chk("halt2_sb_empty", 16'(sb.size()), 16'd0);

    // IE cleared during PUSH_HI
    IF_data = 5'h00;
    reti_tick();
    IF_data = 5'h04; IE_data = 5'h04; pc = 16'h4321; instr_boundary = 1'b1;
    expect_ev(K_PUSH, 16'h0043);
    expect_ev(K_PUSH, 16'h0021);
`ifdef IRQ_DISPATCH_CANCEL_EN
    expect_ev(K_PC,   16'h0000);
`else
    expect_ev(K_ACK,  16'h00E0);
    expect_ev(K_PC,   16'h0050);
`endif
    repeat (3) tick();
    IE_data = 5'h00;
    repeat (3) tick();
    chk("cancel_sb_empty", 16'(sb.size()), 16'd0);
    IE_data = 5'h1F;

    // Reset during PUSH_LO aborts the dispatch
    IF_data = 5'h00;
    reti_tick();
    IF_data = 5'h08; IE_data = 5'h08; pc = 16'h5566; instr_boundary = 1'b1;
    expect_ev(K_PUSH, 16'h0055);
    repeat (4) tick();
    rst = 1'b1;
    m_tick = 1'b1;
    @(negedge clk);
    m_tick = 1'b0;
    chk1("abort_ime", ime, 1'b0);
    chk1("abort_halted", halted, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_push_we", push_we, 1'b0);
    chk("abort_push_data", {8'h00, push_data}, 16'h0000);
    chk1("abort_pc_load", pc_load, 1'b0);
    chk("abort_pc_dout", pc_dout, 16'h0000);
    chk1("abort_ifack_we", IF_ack_we, 1'b0);
    chk("abort_ifack_dout", {8'h00, IF_ack_dout}, 16'h0000);
    rst = 1'b0;
    repeat (3) tick();
    chk1("abort_after_busy", busy, 1'b0);
    chk("abort_sb_empty", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_dispatch.md
IRQ_DISPATCH -- requirements
Module: irq_dispatch

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, system clock.
REQ-002 SHALL have port `rst`: input, 1 bit, reset. It is synchronous and active-high.
REQ-003 SHALL have port `m_tick`: input, 1 bit, one-clk strobe per CPU M-cycle. All state advances only on clocks where `m_tick`=1.
REQ-004 SHALL have ports `IF_data`, `IE_data`: input, 5 bits each, current IF and IE registers.
REQ-005 SHALL have ports `cpu_ei`, `cpu_di`, `cpu_reti`, `cpu_halt`: input, 1 bit each, instruction-executed strobes, qualified by `m_tick`.
REQ-006 SHALL have port `instr_boundary`: input, 1 bit, CPU is at an opcode-fetch boundary.
REQ-007 SHALL have port `pc`: input, 16 bits, PC of the next instruction.
REQ-008 SHALL have port `ime`: output, 1 bit, interrupt master enable.
REQ-009 SHALL have port `halted`: output, 1 bit, CPU in HALT.
REQ-010 SHALL have port `busy`: output, 1 bit, dispatch in progress; CPU stalls while it is high.
REQ-011 SHALL have ports `push_we`: output, 1 bit, and `push_data`: output, 8 bits. These form a stack-push request; the CPU decrements SP and writes.
REQ-012 SHALL have ports `pc_load`: output, 1 bit, and `pc_dout`: output, 16 bits, a PC overwrite.
REQ-013 SHALL have ports `IF_ack_we`: output, 1 bit, and `IF_ack_dout`: output, 8 bits, an IF write that clears the serviced bit.

Function
REQ-014 SHALL implement states IDLE, HALT, WAIT1, WAIT2, PUSH_HI, PUSH_LO, JUMP.
- Each dispatch state lasts exactly one M-cycle.
- A dispatch is 5 M-cycles, from WAIT1 through JUMP.
REQ-015 SHALL define pending = `IF_data` & `IE_data`.
REQ-016 SHALL start a dispatch in IDLE when all of the following hold on one clock:
- `m_tick`, `instr_boundary`, `ime`=1 and pending≠0.
- Action: go to WAIT1, clear `ime`, latch `pc`.
REQ-017 SHALL, on EI, set an internal `ei_delay` flag.
- At the next `m_tick`&`instr_boundary`, `ime` becomes 1 and the flag clears.
- The dispatch check at that same boundary uses the old `ime`=0.
REQ-018 SHALL, on DI, clear `ime` and `ei_delay` at the next clk.
- On RETI, it SHALL set `ime`=1 at the next clk with no delay.
REQ-019 SHALL let a dispatch start win over a DI or EI on the same clock; `ime` ends at 0.
REQ-020 SHALL, on `cpu_halt` in IDLE, go to HALT and drive `halted`=1.
- In HALT, on `m_tick` with pending≠0: go to WAIT1 if `ime`=1, else go to IDLE.
- `halted` drops on the clock it leaves HALT.
REQ-021 SHALL use priority order: lowest set bit wins (VBlank 0 > STAT > Timer > Serial > JOYP 4).
- Vector = 0x0040 + 8·index.
REQ-022 SHALL, in PUSH_HI on `m_tick`, pulse `push_we` for one clk with `push_data` = latched PC[15:8].
- In PUSH_LO on `m_tick`, it SHALL pulse the same way with PC[7:0].
REQ-023 SHALL, in PUSH_LO on `m_tick`, pulse `IF_ack_we` with `IF_ack_dout` = {3'b111, `IF_data` with the selected bit cleared}.
- A peripheral bit rising on that same clk may be lost.
REQ-024 SHALL, in JUMP on `m_tick`, pulse `pc_load` with `pc_dout` = vector, then return to IDLE.
REQ-025 SHALL drive `busy`=1 in WAIT1 through JUMP.
REQ-026 SHALL drive `push_we`, `pc_load` and `IF_ack_we` only as single-clk pulses, and hold them 0 otherwise.
- `push_data`, `pc_dout` and `IF_ack_dout` SHALL be 0 when their strobe is low.
REQ-027 SHALL NOT restart a dispatch while busy; new IF bits wait until IDLE.

Reset
REQ-028 SHALL, on `rst`, enter IDLE at the next clk regardless of state or `m_tick`.
- Outputs `ime`, `halted`, `busy` and all strobes/data = 0; `ei_delay`=0.
REQ-029 SHALL, when reset arrives mid-dispatch, abort the dispatch with no further push, IF-ack or PC-load pulses.

Configuration
REQ-030 SHALL support macro `IRQ_DISPATCH_CANCEL_EN`.
- Defined: the vector and bit are selected from pending sampled at the end of PUSH_HI. If pending=0 there, JUMP loads 0x0000 and `IF_ack_we` is suppressed.
- Undefined: the vector and bit are latched at WAIT1 entry and always serviced.

Structure
REQ-031 SHALL place the state enum, vector base 0x0040, vector stride 8 and IRQ index constants (`IRQ_VBLANK`..`IRQ_JOYP`) in package `gb_irq_pkg`.
REQ-032 SHALL implement priority selection in sub-module `irq_priority_enc` (5-bit in → valid + 3-bit index). It is instantiated once.

Verification
REQ-033 SHALL cover this scenario. Stimulus: `ime`=1, IF=0x04, IE=0x04, boundary, `pc`=0x1234. Required response:
- Pushes 0x12 then 0x34.
- `IF_ack_dout`=0xE0.
- `pc_dout`=0x0050 on the 5th M-cycle; `ime`=0.
REQ-034 SHALL cover this scenario. Stimulus: IF=IE=0x1F. Required response: vector 0x0040; IF ack = 0xFE.
REQ-035 SHALL cover this scenario. Stimulus: EI, then IF&IE≠0 at the next boundary. Required response: no dispatch at that boundary; dispatch starts at the following one.
REQ-036 SHALL cover this scenario. Stimulus: HALT with `ime`=0, then IF=IE=0x01. Required response: `halted` falls; state goes to IDLE; no `push_we` pulse.
REQ-037 SHALL cover this scenario. Stimulus: with the macro defined, IE←0 during PUSH_HI. Required response: `pc_dout`=0x0000; no `IF_ack_we` pulse. With the macro undefined, the original vector is used.
REQ-038 SHALL cover this scenario. Stimulus: `rst` asserted during PUSH_LO. Required response: no `pc_load` pulse; all outputs 0 on the next clk.
